vote_session_ctrl: RTL



---
 rtl/vote_session_ctrl_pkg.sv | 24 ++
 rtl/maj.sv | 11 +
 rtl/vote_session_ctrl_rr_arb5.sv | 28 ++
 rtl/vote_session_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/vote_session_ctrl_pkg.sv
// Shared encodings and constants for the five-member voting session controller.
// Voter bit positions are fixed: s2, s1, s0, teacher, principal from MSB to LSB.
package vote_session_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OPEN  = 2'd1,
      TALLY = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int N_VOTERS = 5;

   localparam logic [2:0] V_S2 = 3'd4;
   localparam logic [2:0] V_S1 = 3'd3;
   localparam logic [2:0] V_S0 = 3'd2;
   localparam logic [2:0] V_T  = 3'd1;
   localparam logic [2:0] V_P  = 3'd0;

   localparam int TIMEOUT_DEF = 16;

   localparam logic [N_VOTERS-1:0] ALL_VOTED = 5'b11111;

endpackage

// File: rtl/maj.sv
// Three-input majority gate.
module maj (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic y_o
);

   assign y_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/vote_session_ctrl_rr_arb5.sv
// Combinational 5-way round-robin arbiter. The search starts at ptr and walks
// downward, wrapping from 0 back to 4; the first requesting index wins.
module rr_arb5 (
   input  logic [4:0] req_i,
   input  logic [2:0] ptr_i,
   output logic [4:0] gnt_o,
   output logic [2:0] gnt_idx_o,
   output logic       any_o
);

   always_comb begin
      logic [2:0] cand;
      cand      = '0;
      gnt_o     = '0;
      gnt_idx_o = '0;
      any_o     = 1'b0;
      for (int k = 0; k < 5; k++) begin
         // Descending distance k from ptr, modulo 5.
         cand = (ptr_i >= 3'(k)) ? (ptr_i - 3'(k)) : (ptr_i + 3'(5 - k));
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            gnt_idx_o   = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vote_session_ctrl.sv
// Voting session sequencer: collects one ballot per committee member, closes on
// full participation or timeout, and reports maj(maj(s2,s1,s0), t, p).
module vote_session_ctrl
   import vote_session_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TW      = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic [4:0] vote_req_i,
   input  logic [4:0] vote_val_i,
   output logic [4:0] vote_ack_o,
   output logic [4:0] voted_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       result_o,
   output logic       timed_out_o
);

   state_e          state_q, state_d;
   logic [2:0]      ptr_q, ptr_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [4:0]      voted_q, voted_d;
   logic [4:0]      ballot_q, ballot_d;
   logic [4:0]      ack_q, ack_d;
   logic            result_q, result_d;
   logic            timed_out_q, timed_out_d;

   logic [4:0]      arb_gnt;
   logic [2:0]      arb_idx;
   logic            arb_any;
   logic            student_maj;
   logic            tally_res;
   logic            timer_expired;

   // Already-voted members are masked so a held request is never acked twice.
   rr_arb5 u_arb (
      .req_i     (vote_req_i & ~voted_q),
      .ptr_i     (ptr_q),
      .gnt_o     (arb_gnt),
      .gnt_idx_o (arb_idx),
      .any_o     (arb_any)
   );

   maj u_maj_students (
      .a_i (ballot_q[V_S2]),
      .b_i (ballot_q[V_S1]),
      .c_i (ballot_q[V_S0]),
      .y_o (student_maj)
   );

   maj u_maj_final (
      .a_i (student_maj),
      .b_i (ballot_q[V_T]),
      .c_i (ballot_q[V_P]),
      .y_o (tally_res)
   );

   assign timer_expired = (timer_q == TW'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      timer_d     = timer_q;
      voted_d     = voted_q;
      ballot_d    = ballot_q;
      ack_d       = '0;
      result_d    = result_q;
      timed_out_d = timed_out_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d     = OPEN;
               voted_d     = '0;
               ballot_d    = '0;
               timer_d     = '0;
               result_d    = 1'b0;
               timed_out_d = 1'b0;
               ptr_d       = V_S2;
            end
         end
         OPEN: begin
            timer_d = timer_q + 1'b1;
            if (arb_any) begin
               ballot_d = (ballot_q & ~arb_gnt) | (vote_val_i & arb_gnt);
               voted_d  = voted_q | arb_gnt;
               ack_d    = arb_gnt;
               ptr_d    = (arb_idx == 3'd0) ? V_S2 : (arb_idx - 3'd1);
            end
            // A grant landing on the timeout edge still counts toward completion.
            if ((voted_d == ALL_VOTED) || timer_expired) begin
               state_d     = TALLY;
               timed_out_d = timer_expired && (voted_d != ALL_VOTED);
            end
         end
         TALLY: begin
            result_d = tally_res;
            state_d  = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= V_S2;
         timer_q     <= '0;
         voted_q     <= '0;
         ballot_q    <= '0;
         ack_q       <= '0;
         result_q    <= 1'b0;
         timed_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         timer_q     <= timer_d;
         voted_q     <= voted_d;
         ballot_q    <= ballot_d;
         ack_q       <= ack_d;
         result_q    <= result_d;
         timed_out_q <= timed_out_d;
      end
   end

   assign vote_ack_o  = ack_q;
   assign voted_o     = voted_q;
   assign busy_o      = (state_q == OPEN) || (state_q == TALLY);
   assign done_o      = (state_q == DONE);
   assign result_o    = result_q;
   assign timed_out_o = timed_out_q;

endmodule
